// File: rtl/conv_word_serializer.sv
// Word-to-byte-slot transmitter for the conv pixel buffer link.
// Queues 24-bit words and emits them as c=01/10/11 slots with pix one cycle behind.
module conv_word_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter int GAP        = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [23:0]      in_word,
    output logic             in_ready,
    input  logic             hold,
    output logic [1:0]       c,
    output logic [7:0]       pix,
    output logic             word_done,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, S0, S1, S2, GAPW} state_t;

    logic [23:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    state_t           r_state;
    state_t           w_nstate;
    logic [23:0]      r_w;
    logic [3:0]       r_gcnt;
    logic [3:0]       w_ngcnt;
    logic [1:0]       r_c;
    logic [1:0]       w_nc;
    logic [7:0]       r_pix;
    logic             r_done;
    logic [CNT_W-1:0] r_wcnt;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_idle_like;

    assign in_ready   = (r_cnt < (AW+1)'(FIFO_DEPTH));
    assign w_push     = in_valid & in_ready;
    assign w_empty    = (r_cnt == '0);
    assign c          = r_c;
    assign pix        = r_pix;
    assign word_done  = r_done;
    assign word_count = r_wcnt;
    assign busy       = !w_empty || (r_state != IDLE) || (r_c != 2'b00);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= in_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // S2 (GAP=0) and the last gap cycle double as IDLE to keep a 3+GAP cadence
    always_comb begin
        w_nstate    = r_state;
        w_nc        = 2'b00;
        w_ngcnt     = r_gcnt;
        w_pop       = 1'b0;
        w_idle_like = 1'b0;
        unique case (r_state)
            IDLE: w_idle_like = 1'b1;
            S0: begin
                if (!hold) begin
                    w_nc     = 2'b10;
                    w_nstate = S1;
                end
            end
            S1: begin
                if (!hold) begin
                    w_nc     = 2'b11;
                    w_nstate = S2;
                end
            end
            S2: begin
                if (GAP > 0) begin
                    w_ngcnt  = 4'(GAP - 1);
                    w_nstate = GAPW;
                end else begin
                    w_idle_like = 1'b1;
                end
            end
            GAPW: begin
                if (r_gcnt == 4'd0) w_idle_like = 1'b1;
                else                w_ngcnt = r_gcnt - 4'd1;
            end
            default: w_nstate = IDLE;
        endcase
        if (w_idle_like) begin
            w_nstate = IDLE;
            if (!w_empty && !hold) begin
                w_pop    = 1'b1;
                w_nc     = 2'b01;
                w_nstate = S0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gcnt  <= '0;
            r_c     <= 2'b00;
            r_w     <= '0;
            r_pix   <= '0;
            r_done  <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_nstate;
            r_gcnt  <= w_ngcnt;
            r_c     <= w_nc;
            if (w_pop) r_w <= r_mem[r_rp];
            // pix uses the pre-edge word, so a same-edge reload is harmless
            case (r_c)
                2'b01:   r_pix <= r_w[7:0];
                2'b10:   r_pix <= r_w[15:8];
                2'b11:   r_pix <= r_w[23:16];
                default: r_pix <= r_pix;
            endcase
            r_done <= (r_c == 2'b11);
            if (r_c == 2'b11) r_wcnt <= r_wcnt + 1'b1;
        end
    end

endmodule
